// File: rtl/prt_dprx_scrm.sv
// DisplayPort RX lane descrambler: keeps the x^16+x^5+x^4+x^3+1 LFSR in step across
// P_SPL symbols per clock, resynchronises it on SR, and tracks lock via SR spacing.
module prt_dprx_scrm #(
    parameter int P_SIM = 0,
    parameter int P_SPL = 2
) (
    input  logic                 RST_IN,
    input  logic                 CLK_IN,
    input  logic                 CTL_EN_IN,
    input  logic [P_SPL-1:0]     LNK_K_IN,
    input  logic [8*P_SPL-1:0]   LNK_DAT_IN,
    output logic [P_SPL-1:0]     LNK_K_OUT,
    output logic [8*P_SPL-1:0]   LNK_DAT_OUT,
    output logic                 STA_LOCK_OUT,
    output logic                 STA_SR_ERR_OUT
);

    localparam int          P_SR_TMO  = (P_SIM != 0) ? 16 : 1024;
    localparam logic [11:0] TMO_CNT   = 12'(P_SR_TMO);
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;
    localparam logic [7:0]  SYM_BS    = 8'hBC;
    localparam logic [7:0]  SYM_SR    = 8'h1C;

    typedef enum logic {UNLOCK, LOCK} state_t;

    logic               en_r;
    logic [15:0]        lfsr_q;
    logic [15:0]        lfsr_end;
    logic [P_SPL-1:0]   k_nxt;
    logic [8*P_SPL-1:0] dat_nxt;
    logic               any_sr;
    logic               any_mark;
    state_t             state_q, state_nxt;
    logic [11:0]        cnt_q, cnt_nxt, cnt_inc;
    logic               tmo;

    // Galois form of the serial LFSR: 8 single-bit shifts per symbol.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int b = 0; b < 8; b++) begin
            if (r[15])
                r = {r[14:0], 1'b0} ^ 16'h0039;
            else
                r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] lfsr_mask(input logic [15:0] s);
        logic [7:0] m;
        m = 8'h00;
        for (int j = 0; j < 8; j++)
            m[j] = s[15-j];
        return m;
    endfunction

    always_ff @(posedge CLK_IN)
        en_r <= CTL_EN_IN;

    // Sublane chain: each symbol gets the state left by the previous one (or the seed after SR).
    always_comb begin
        logic [15:0] s;
        logic [7:0]  d;
        logic        k;
        logic        sr;
        s        = en_r ? lfsr_q : LFSR_SEED;
        k_nxt    = LNK_K_IN;
        dat_nxt  = LNK_DAT_IN;
        any_sr   = 1'b0;
        any_mark = 1'b0;
        for (int i = 0; i < P_SPL; i++) begin
            k  = LNK_K_IN[i];
            d  = LNK_DAT_IN[8*i +: 8];
            sr = en_r && k && (d == SYM_SR);
            if (en_r) begin
                if (sr)
                    dat_nxt[8*i +: 8] = SYM_BS;
                else if (!k)
                    dat_nxt[8*i +: 8] = d ^ lfsr_mask(s);
                if (k && (d == SYM_BS || d == SYM_SR))
                    any_mark = 1'b1;
            end
            any_sr = any_sr | sr;
            s = sr ? LFSR_SEED : lfsr_adv8(s);
        end
        lfsr_end = s;
    end

    // SR wins over a simultaneous timeout: the lock is refreshed and no error is raised.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        tmo       = 1'b0;
        cnt_inc   = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
        if (!en_r) begin
            state_nxt = UNLOCK;
            cnt_nxt   = 12'd0;
        end else begin
            case (state_q)
                UNLOCK: begin
                    if (any_sr) begin
                        state_nxt = LOCK;
                        cnt_nxt   = 12'd0;
                    end
                end
                LOCK: begin
                    if (any_sr) begin
                        cnt_nxt = 12'd0;
                    end else if (any_mark) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= TMO_CNT) begin
                            state_nxt = UNLOCK;
                            tmo       = 1'b1;
                        end
                    end
                end
                default: state_nxt = UNLOCK;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            lfsr_q         <= LFSR_SEED;
            LNK_K_OUT      <= '0;
            LNK_DAT_OUT    <= '0;
            state_q        <= UNLOCK;
            cnt_q          <= 12'd0;
            STA_LOCK_OUT   <= 1'b0;
            STA_SR_ERR_OUT <= 1'b0;
        end else begin
            lfsr_q         <= en_r ? lfsr_end : LFSR_SEED;
            LNK_K_OUT      <= k_nxt;
            LNK_DAT_OUT    <= dat_nxt;
            state_q        <= state_nxt;
            cnt_q          <= cnt_nxt;
            STA_LOCK_OUT   <= (state_q == LOCK);
            STA_SR_ERR_OUT <= tmo;
        end
    end

endmodule

// File: tb/tb_prt_dprx_scrm.sv
// Bench for prt_dprx_scrm: a 4-lane and a 2-lane instance share one stimulus stream;
// a keystream/lock model predicts every output cycle, plus directed literal checks.
module tb_prt_dprx_scrm;

    localparam int          TMO = 16;
    localparam logic [7:0]  SR  = 8'h1C;
    localparam logic [7:0]  BS  = 8'hBC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctl_en = 1'b1;
    logic [3:0]  k_in = 4'h0;
    logic [31:0] dat_in = 32'h0;

    logic [3:0]  k4_out;
    logic [31:0] dat4_out;
    logic        lock4, err4;
    logic [1:0]  k2_out;
    logic [15:0] dat2_out;
    logic        lock2, err2;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;
    int nerr4, nerr2;

    always #5 clk = ~clk;

    prt_dprx_scrm #(.P_SIM(1), .P_SPL(4)) u_dut4 (
        .RST_IN(rst), .CLK_IN(clk), .CTL_EN_IN(ctl_en),
        .LNK_K_IN(k_in), .LNK_DAT_IN(dat_in),
        .LNK_K_OUT(k4_out), .LNK_DAT_OUT(dat4_out),
        .STA_LOCK_OUT(lock4), .STA_SR_ERR_OUT(err4)
    );

    prt_dprx_scrm #(.P_SIM(1), .P_SPL(2)) u_dut2 (
        .RST_IN(rst), .CLK_IN(clk), .CTL_EN_IN(ctl_en),
        .LNK_K_IN(k_in[1:0]), .LNK_DAT_IN(dat_in[15:0]),
        .LNK_K_OUT(k2_out), .LNK_DAT_OUT(dat2_out),
        .STA_LOCK_OUT(lock2), .STA_SR_ERR_OUT(err2)
    );

    typedef struct {
        logic [15:0] ks;
        bit          locked;
        int          marks;
    } mdl_t;

    mdl_t        m4, m2;
    logic        en_m = 1'b0;
    logic [3:0]  exp_k4 = '0;
    logic [31:0] exp_dat4 = '0;
    logic        exp_lock4 = 1'b0, exp_err4 = 1'b0;
    logic [1:0]  exp_k2 = '0;
    logic [15:0] exp_dat2 = '0;
    logic        exp_lock2 = 1'b0, exp_err2 = 1'b0;

    // One link clock of the reference: serial keystream bits (MSB shifted out first),
    // SR reseeds after itself, lock is lost after TMO marked cycles with no SR.
    function automatic void model_cycle(input int spl, input bit en, input logic [3:0] k,
                                        input logic [31:0] d, inout mdl_t m,
                                        output logic [3:0] ko, output logic [31:0] dout,
                                        output bit err);
        bit         any_sr, any_bs;
        logic [7:0] sym, key;
        ko = k;
        dout = d;
        err = 1'b0;
        any_sr = 1'b0;
        any_bs = 1'b0;
        if (!en) begin
            m.ks = 16'hFFFF;
            m.locked = 1'b0;
            m.marks = 0;
            return;
        end
        for (int i = 0; i < spl; i++) begin
            sym = d[8*i +: 8];
            for (int j = 0; j < 8; j++) begin
                key[j] = m.ks[15];
                m.ks = {m.ks[14:0], 1'b0} ^ (m.ks[15] ? 16'h0039 : 16'h0000);
            end
            if (k[i]) begin
                if (sym == SR) begin
                    dout[8*i +: 8] = BS;
                    m.ks = 16'hFFFF;
                    any_sr = 1'b1;
                end else if (sym == BS) begin
                    any_bs = 1'b1;
                end
            end else begin
                dout[8*i +: 8] = sym ^ key;
            end
        end
        if (any_sr) begin
            m.locked = 1'b1;
            m.marks = 0;
        end else if (m.locked && any_bs) begin
            m.marks++;
            if (m.marks == TMO) begin
                m.locked = 1'b0;
                m.marks = 0;
                err = 1'b1;
            end
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] k, input logic [31:0] d);
        @(posedge clk);
        #1;
        k_in = k;
        dat_in = d;
    endtask

    always @(posedge clk)
        en_m <= ctl_en;

    always @(posedge clk or posedge rst) begin : model4
        mdl_t        mt;
        logic [3:0]  ko;
        logic [31:0] dout;
        bit          e;
        if (rst) begin
            m4 <= '{ks: 16'hFFFF, locked: 1'b0, marks: 0};
            exp_k4 <= '0; exp_dat4 <= '0; exp_lock4 <= 1'b0; exp_err4 <= 1'b0;
        end else begin
            mt = m4;
            model_cycle(4, en_m, k_in, dat_in, mt, ko, dout, e);
            exp_lock4 <= m4.locked;
            m4 <= mt;
            exp_k4 <= ko;
            exp_dat4 <= dout;
            exp_err4 <= e;
        end
    end

    always @(posedge clk or posedge rst) begin : model2
        mdl_t        mt;
        logic [3:0]  ko;
        logic [31:0] dout;
        bit          e;
        if (rst) begin
            m2 <= '{ks: 16'hFFFF, locked: 1'b0, marks: 0};
            exp_k2 <= '0; exp_dat2 <= '0; exp_lock2 <= 1'b0; exp_err2 <= 1'b0;
        end else begin
            mt = m2;
            model_cycle(2, en_m, {2'b00, k_in[1:0]}, {16'h0000, dat_in[15:0]}, mt, ko, dout, e);
            exp_lock2 <= m2.locked;
            m2 <= mt;
            exp_k2 <= ko[1:0];
            exp_dat2 <= dout[15:0];
            exp_err2 <= e;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("cyc_k4", k4_out, exp_k4);
            checkOutput("cyc_dat4", dat4_out, exp_dat4);
            checkOutput("cyc_lock4", lock4, exp_lock4);
            checkOutput("cyc_err4", err4, exp_err4);
            checkOutput("cyc_k2", k2_out, exp_k2);
            checkOutput("cyc_dat2", dat2_out, exp_dat2);
            checkOutput("cyc_lock2", lock2, exp_lock2);
            checkOutput("cyc_err2", err2, exp_err2);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_dat4", dat4_out, 32'h0);
        checkOutput("reset_k4", k4_out, 4'h0);
        checkOutput("reset_lock4", lock4, 1'b0);
        checkOutput("reset_err4", err4, 1'b0);
        checkOutput("reset_dat2", dat2_out, 16'h0);
        rst = 1'b0;
        applyStimulus(4'h0, 32'h0);
        applyStimulus(4'h0, 32'h0);

        // SR in lane 1, then FF/17 which must descramble to zero on the 2-lane part
        applyStimulus(4'b0010, {8'h00, 8'h00, SR, 8'h55});
        applyStimulus(4'b0000, {8'h00, 8'h00, 8'h17, 8'hFF});
        checkOutput("sr_as_bs_k2", k2_out, 2'b10);
        checkOutput("sr_as_bs_dat2", dat2_out[15:8], BS);
        applyStimulus(4'b0001, {8'hC0, 8'h17, 8'hFF, SR});
        checkOutput("descr_dat2", dat2_out, 16'h0000);
        checkOutput("descr_k2", k2_out, 2'b00);
        checkOutput("lock2_after_sr", lock2, 1'b1);
        applyStimulus(4'h0, 32'h0);
        checkOutput("descr_dat4", dat4_out, {8'h00, 8'h00, 8'h00, BS});
        checkOutput("descr_k4", k4_out, 4'b0001);
        applyStimulus(4'h0, 32'h0);
        checkOutput("lock4_after_sr", lock4, 1'b1);

        // Sixteen BS cycles without SR: one error pulse, lock drops
        nerr4 = 0;
        nerr2 = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus((i < 16) ? 4'b0001 : 4'b0000, (i < 16) ? {24'h0, BS} : 32'h0);
            nerr4 += int'(err4);
            nerr2 += int'(err2);
        end
        checkOutput("tmo_pulses4", nerr4, 1);
        checkOutput("tmo_pulses2", nerr2, 1);
        checkOutput("tmo_unlock4", lock4, 1'b0);
        checkOutput("tmo_unlock2", lock2, 1'b0);

        // SR landing on the 16th marked cycle keeps lock and clears the count
        nerr4 = 0;
        nerr2 = 0;
        applyStimulus(4'b0001, {24'h0, SR});
        for (int i = 0; i < 34; i++) begin
            if (i < 15 || (i > 15 && i < 31))
                applyStimulus(4'b0001, {24'h0, BS});
            else if (i == 15)
                applyStimulus(4'b0001, {24'h0, SR});
            else
                applyStimulus(4'b0000, 32'h0);
            nerr4 += int'(err4);
            nerr2 += int'(err2);
        end
        checkOutput("sr_prio_noerr4", nerr4, 0);
        checkOutput("sr_prio_noerr2", nerr2, 0);
        checkOutput("sr_prio_lock4", lock4, 1'b1);
        checkOutput("sr_prio_lock2", lock2, 1'b1);

        // Disabled: bypass, SR left as is, lock forced low
        applyStimulus(4'h0, 32'h0);
        ctl_en = 1'b0;
        applyStimulus(4'h0, 32'h0);
        applyStimulus(4'b0001, {8'h00, 8'h00, 8'h5A, SR});
        applyStimulus(4'h0, 32'h0);
        checkOutput("bypass_k2", k2_out, 2'b01);
        checkOutput("bypass_dat2", dat2_out, 16'h5A1C);
        checkOutput("bypass_dat4", dat4_out, 32'h00005A1C);
        checkOutput("bypass_lock2", lock2, 1'b0);
        checkOutput("bypass_lock4", lock4, 1'b0);

        // Reset mid-packet while locked
        ctl_en = 1'b1;
        applyStimulus(4'h0, 32'h0);
        applyStimulus(4'h0, 32'h0);
        applyStimulus(4'b0001, {24'h0, SR});
        applyStimulus(4'h0, 32'h11223344);
        applyStimulus(4'h0, 32'h55667788);
        applyStimulus(4'h0, 32'h99AABBCC);
        checkOutput("pre_rst_lock4", lock4, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_dat4", dat4_out, 32'h0);
        checkOutput("rst_async_k4", k4_out, 4'h0);
        checkOutput("rst_async_lock4", lock4, 1'b0);
        checkOutput("rst_async_dat2", dat2_out, 16'h0);
        checkOutput("rst_async_lock2", lock2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(4'b0001, {8'h12, 8'h34, 8'h56, BS});
        checkOutput("post_rst_nolock4", lock4, 1'b0);
        checkOutput("post_rst_nolock2", lock2, 1'b0);
        applyStimulus(4'b0001, {24'h0, SR});
        applyStimulus(4'h0, 32'h0);
        applyStimulus(4'h0, 32'h0);
        checkOutput("relock4", lock4, 1'b1);
        checkOutput("relock2", lock2, 1'b1);

        applyStimulus(4'h0, 32'h0);
        applyStimulus(4'h0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
